// File: rtl/prog_down_timer.sv
// Programmable down-counting interval timer with one-shot and
// auto-reload modes and a count enable for prescaled operation.
module prog_down_timer #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_period,
  input  logic [N-1:0] period_in,
  input  logic         start,
  input  logic         stop,
  input  logic         periodic,
  input  logic         en,
  output logic [N-1:0] q,
  output logic [N-1:0] period_q,
  output logic         busy,
  output logic         done_tick
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [N-1:0] ONE = N'(1);

  state_t       state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] period_d;
  logic         mode_q, mode_d;
  logic         done_q, done_d;
  logic [N-1:0] p_eff;

  assign p_eff = wr_period ? period_in : period_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    period_d = p_eff;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start && !stop && p_eff != '0) begin
          state_d = RUN;
          cnt_d   = p_eff;
          mode_d  = periodic;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (start) begin
          if (p_eff != '0) begin
            cnt_d  = p_eff;
            mode_d = periodic;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else if (en && cnt_q == ONE) begin
          done_d = 1'b1;
          // reload of a zeroed period ends the run: q==0 only in IDLE
          if (mode_q && period_q != '0) begin
            cnt_d = period_q;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else if (en) begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign q         = cnt_q;
  assign busy      = (state_q == RUN);
  assign done_tick = done_q;

endmodule

// File: tb/tb_prog_down_timer.sv
// Scoreboard bench for prog_down_timer: directed scenarios then
// randomized traffic checked against a behavioural model.
module tb_prog_down_timer;

  logic       clk = 1'b0;
  logic       reset, wr_period, start, stop, periodic, en;
  logic [7:0] period_in;
  logic [7:0] q, period_q;
  logic       busy, done_tick;

  typedef struct {
    logic [7:0] q;
    logic [7:0] pq;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_fifo[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int m_rem = 0;
  int m_per = 0;
  bit m_run = 0;
  bit m_mode = 0;
  bit m_tick = 0;

  prog_down_timer #(.N(8)) dut (
    .clk(clk), .reset(reset), .wr_period(wr_period),
    .period_in(period_in), .start(start), .stop(stop),
    .periodic(periodic), .en(en), .q(q), .period_q(period_q),
    .busy(busy), .done_tick(done_tick)
  );

  always #5 clk = ~clk;

  task automatic model(input bit r, input bit wr, input int pi,
                       input bit st, input bit sp, input bit pe,
                       input bit e);
    int peff;
    if (r) begin
      m_run = 0; m_rem = 0; m_per = 0; m_mode = 0; m_tick = 0;
      return;
    end
    m_tick = 0;
    peff = wr ? pi : m_per;
    if (!m_run) begin
      if (st && !sp && peff != 0) begin
        m_run = 1; m_rem = peff; m_mode = pe;
      end
    end else if (sp) begin
      m_run = 0; m_rem = 0;
    end else if (st) begin
      if (peff != 0) begin
        m_rem = peff; m_mode = pe;
      end else begin
        m_run = 0; m_rem = 0;
      end
    end else if (e) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_tick = 1;
        if (m_mode && m_per != 0) m_rem = m_per;
        else m_run = 0;
      end
    end
    m_per = peff;
  endtask

  task automatic step(input bit r, input bit wr, input int pi,
                      input bit st, input bit sp, input bit pe,
                      input bit e);
    exp_t x;
    reset = r; wr_period = wr; period_in = pi[7:0];
    start = st; stop = sp; periodic = pe; en = e;
    model(r, wr, pi, st, sp, pe, e);
    x.q = m_rem[7:0]; x.pq = m_per[7:0];
    x.busy = m_run; x.done = m_tick;
    @(posedge clk);
    #1;
    exp_fifo.push_back(x);
  endtask

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time,
               act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_fifo.size() > 0) begin
      exp_t x;
      x = exp_fifo.pop_front();
      chk("q", int'(q), int'(x.q));
      chk("period_q", int'(period_q), int'(x.pq));
      chk("busy", int'(busy), int'(x.busy));
      chk("done_tick", int'(done_tick), int'(x.done));
    end
  end

  initial begin
    reset = 1'b1; wr_period = 1'b0; period_in = '0;
    start = 1'b0; stop = 1'b0; periodic = 1'b0; en = 1'b0;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 1, 1);
    // one-shot, period 5
    step(0, 1, 5, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, 0, 1);
    // periodic, period 3, then stop
    step(0, 1, 3, 1, 0, 1, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    // gated counting, period 2 one-shot
    step(0, 1, 2, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0, (i % 4) == 3);
    // stop coinciding with expiry
    step(0, 0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    // zero period start ignored, then full scale
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 1);
    step(0, 1, 255, 1, 0, 0, 1);
    for (int i = 0; i < 258; i++) step(0, 0, 0, 0, 0, 0, 1);
    // period write during RUN, reload and restart
    step(0, 1, 6, 1, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 1, 2, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 1);
    // reset mid-run with q=7
    step(0, 1, 9, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int pi;
      pi = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 255)
                                         : $urandom_range(0, 6);
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 11) == 0, pi,
           $urandom_range(0, 13) == 0,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) != 0);
    end
    begin
      int guard;
      guard = 0;
      while (exp_fifo.size() > 0 && guard < 20) begin
        @(posedge clk);
        guard++;
      end
      chk("scoreboard_drain", exp_fifo.size(), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_down_timer.md
Name: prog_down_timer

Overview:
Programmable down-counting interval timer, the complement of the universal up/down binary counter. Software or an FSM writes a period, starts the timer, and receives a one-cycle done_tick when the period expires. Supports one-shot and periodic (auto-reload) modes, with an external enable input for prescaled counting. Used for timeouts, baud/refresh interval generation and delay sequencing in the same designs that use the binary counter.

Parameters:
N, 8, width of the period register and the count value

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
wr_period  input  1  write strobe for the period register
period_in  input  N  period value written when wr_period=1
start  input  1  start or restart the timer
stop  input  1  abort the timer; return to idle without done_tick
periodic  input  1  mode select, sampled only when a start is accepted; 1 = auto-reload, 0 = one-shot
en  input  1  count enable; decrements occur only on cycles with en=1
q  output  N  current remaining count (registered)
period_q  output  N  current period register contents
busy  output  1  1 while in RUN state
done_tick  output  1  registered one-cycle pulse on expiry

Behaviour:
- Reset (synchronous, reset=1 at a rising edge): state=IDLE, q=0, period_q=0, mode=0, done_tick=0, busy=0. Reset overrides all other inputs, including in RUN.
- Period register: on any edge with wr_period=1, period_q<=period_in, in any state. A write during RUN does not change the running q; it takes effect at the next start or periodic reload.
- Effective period P_eff = period_in if wr_period=1 on the same edge, else period_q.
- Two states: IDLE and RUN. busy=1 exactly in RUN.
- IDLE transitions:
  - start=1, stop=0, P_eff!=0: go to RUN, q<=P_eff, mode<=periodic.
  - start=1 with P_eff=0: ignored; remain in IDLE, q stays 0, no done_tick.
  - Otherwise: hold, with q=0.
- RUN transitions, in priority order:
  - stop=1: go to IDLE, q<=0, no done_tick. stop also wins over a simultaneous start or expiry.
  - start=1: restart, q<=P_eff, mode<=periodic, no done_tick, even if an expiry would coincide. If P_eff=0, go to IDLE with q<=0 and no done_tick.
  - en=1 and q==1 (expiry): done_tick<=1. If mode=1, q<=period_q and stay in RUN. If mode=0, q<=0 and go to IDLE.
  - en=1 and q>1: q<=q-1.
  - en=0: hold.
- done_tick is 1 only in the cycle following an expiry edge; otherwise 0. There are no back-to-back ticks unless periodic mode with period 1 and en=1 continuously, in which case done_tick is high every cycle.
- Timing: the timer expires on the P-th enabled edge after the start edge. With en=1 continuously, done_tick is high during cycle k+P, where the start edge is k.
- Arithmetic: the count never wraps. q==0 occurs only in IDLE, so no underflow path exists. The full-scale period 2**N-1 is legal.
- Idle outputs: q=0 and busy=0, except period_q, which retains its value.

Test Plan:
- Reset, then write period_in=5; start one-shot with en=1 → q reads 5,4,3,2,1 on successive cycles; done_tick high for exactly 1 cycle as q returns to 0; busy falls in the same cycle; period_q=5.
- Periodic mode, P=3, en=1 for 10 cycles → done_tick every 3rd cycle; q cycles 3,2,1,3,2,1…; busy stays 1. Then assert stop → q=0, busy=0, no tick.
- Gating with en=1 every 4th cycle, P=2, one-shot → done_tick 8 cycles after start. Also assert stop in the cycle of expiry → no done_tick, IDLE.
- Start with period_q=0 → ignored, busy=0. Then wr_period with period_in=255 and start on the same edge → q=255, mode latched, done_tick after 255 enabled cycles.
- During RUN (q=4, P=6), write period_in=2 → q continues 3,2,1. Periodic reload loads 2, and start in RUN restarts from 2 with no tick.
- Assert reset mid-RUN with q=7 → next cycle q=0, busy=0, period_q=0, done_tick=0.
